// File: rtl/core_region_reader.sv
// Core-side reader for the pixel-region token readout: walks the token chain per trigger and queues words to the core.
// Optional CORE_READER_HITCNT_EN: the end-of-event word carries the saturated per-event hit count.
module core_region_reader #(
   parameter int DATA_BITS  = 24,
   parameter int SETTLE_CYC = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_BITS   = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 ReqValid,
   input  logic [4:0]           ReqId,
   output logic                 ReqReady,
   output logic                 TokIn,
   output logic [4:0]           TrigIdReq,
   input  logic                 TokChain,
   output logic                 Read,
   input  logic [DATA_BITS-1:0] RegData,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [DATA_BITS-1:0] OutData,
   output logic [4:0]           OutTag,
   output logic                 OutEoe
);

   localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
   localparam logic [PTR_BITS:0] ROOM_LIMIT = (PTR_BITS+1)'(FIFO_DEPTH - 2);

   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, READ, CAPTURE, EOE} state_t;

   state_t state, state_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic [4:0] trig_id, trig_nxt;
   logic push, push_eoe, pop;
   logic [DATA_BITS-1:0] push_data, eoe_payload;

   logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
   logic [PTR_BITS:0]   count;
   logic [DATA_BITS-1:0] data_mem [FIFO_DEPTH];
   logic [4:0]           tag_mem  [FIFO_DEPTH];
   logic                 eoe_mem  [FIFO_DEPTH];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         trig_id    <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         trig_id    <= trig_nxt;
      end
   end

   // Reads are only issued with room for both the data word and the closing EOE word.
   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      trig_nxt   = trig_id;
      push       = 1'b0;
      push_eoe   = 1'b0;
      push_data  = '0;
      ReqReady   = 1'b0;
      Read       = 1'b0;
      unique case (state)
         IDLE: begin
            ReqReady = ReqValid;
            if (ReqValid) begin
               trig_nxt   = ReqId;
               settle_nxt = SETTLE_LOAD;
               state_nxt  = SETTLE;
            end
         end
         SETTLE: begin
            settle_nxt = settle_cnt - 4'd1;
            if (settle_cnt == 4'd1) state_nxt = CHECK;
         end
         CHECK: begin
            if (!TokChain)               state_nxt = EOE;
            else if (count <= ROOM_LIMIT) state_nxt = READ;
         end
         READ: begin
            Read      = 1'b1;
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            push       = 1'b1;
            push_data  = RegData;
            settle_nxt = SETTLE_LOAD;
            state_nxt  = SETTLE;
         end
         EOE: begin
            push      = 1'b1;
            push_eoe  = 1'b1;
            push_data = eoe_payload;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign TokIn     = (state == SETTLE) || (state == CHECK) || (state == READ) || (state == CAPTURE);
   assign TrigIdReq = trig_id;

`ifdef CORE_READER_HITCNT_EN
   logic [CNT_BITS-1:0] hit_cnt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         hit_cnt <= '0;
      else if (state == IDLE && ReqValid)
         hit_cnt <= '0;
      else if (state == CAPTURE && hit_cnt != '1)
         hit_cnt <= hit_cnt + CNT_BITS'(1);
   end

   assign eoe_payload = DATA_BITS'(hit_cnt);
`else
   assign eoe_payload = '0;
`endif

   assign OutValid = (count != '0);
   assign pop      = OutValid && OutReady;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_BITS+1)'(1);
            2'b01:   count <= count - (PTR_BITS+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         data_mem[wr_ptr] <= push_data;
         tag_mem[wr_ptr]  <= trig_id;
         eoe_mem[wr_ptr]  <= push_eoe;
      end
   end

   // Head fields are forced to zero when empty so reset leaves the outputs clean.
   assign OutData = OutValid ? data_mem[rd_ptr] : '0;
   assign OutTag  = OutValid ? tag_mem[rd_ptr]  : '0;
   assign OutEoe  = OutValid ? eoe_mem[rd_ptr]  : 1'b0;

endmodule
